// File: rtl/bfm_apbtoahb_pkg.sv
// rtl/bfm_apbtoahb_pkg.sv - shared state encoding and fixed AHB attributes for the APB-to-AHB bridge
package bfm_apbtoahb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } bridge_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

endpackage

// File: rtl/bfm_apbtoahb.sv
// rtl/bfm_apbtoahb.sv - APB slave to AHB master bridge, one single-word transfer outstanding
module bfm_apbtoahb
    import bfm_apbtoahb_pkg::*;
#(
    parameter int TPD = 1
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    // RTL outputs are zero-delay; TPD only describes the modelled output delay.
    if (TPD < 0) begin : g_tpd_range
        $error("bfm_apbtoahb: TPD must be non-negative");
    end

    bridge_state_t r_state;
    bridge_state_t w_next;

    logic [31:0] r_addr;
    logic        r_write;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_abort;

    logic w_setup;
    logic w_pready;
    logic w_discard;

    assign w_setup   = (r_state == ST_IDLE) && PSEL && !PENABLE;
    assign w_pready  = (r_state == ST_RESP) && PSEL && PENABLE && !r_abort;
    // A master that lets go of PSEL mid-transfer never sees this result.
    assign w_discard = r_abort || !PSEL;

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_setup) w_next = ST_ADDR;
            ST_ADDR: if (HREADY) w_next = ST_DATA;
            ST_DATA: if (HREADY) w_next = ST_RESP;
            ST_RESP: if (w_pready || !PSEL || r_abort) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            if (w_setup) begin
                r_addr  <= PADDR;
                r_write <= PWRITE;
                r_wdata <= PWDATA;
                r_err   <= 1'b0;
                r_abort <= 1'b0;
            end
            if ((r_state == ST_ADDR || r_state == ST_DATA) && !PSEL) begin
                r_abort <= 1'b1;
            end
            // Error is sticky across the whole data phase, including the HREADY=0 first half.
            if (r_state == ST_DATA) begin
                if (HRESP) begin
                    r_err <= 1'b1;
                end
                if (HREADY && !r_write && !w_discard) begin
                    r_rdata <= HRDATA;
                end
            end
        end
    end

    assign HTRANS    = (r_state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = r_addr;
    assign HWRITE    = r_write;
    assign HWDATA    = r_wdata;
    assign HSIZE     = HSIZE_WORD;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DEFAULT;
    assign HMASTLOCK = 1'b0;
    assign PRDATA    = r_rdata;
    assign PREADY    = w_pready;
    assign PSLVERR   = w_pready & r_err;

endmodule

// File: tb/tb_bfm_apbtoahb.sv
// tb/tb_bfm_apbtoahb.sv - scoreboard bench for the APB-to-AHB bridge
module tb_bfm_apbtoahb;

    logic        HCLK = 1'b0;
    logic        HRESETN = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] HRDATA = '0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;

    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;

    bfm_apbtoahb #(.TPD(1)) dut (
        .HCLK(HCLK), .HRESETN(HRESETN),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        string       name;
        logic [31:0] prdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] model_prdata = '0;

    int          sl_waits = 0;
    logic        sl_err = 1'b0;
    logic [31:0] sl_rdata = '0;
    logic        in_dp = 1'b0;
    logic        dp_last = 1'b0;
    logic        nonseq_acc = 1'b0;
    int          wcnt = 0;
    int          n_dp_done = 0;
    int          n_nonseq = 0;

    always @(posedge HCLK) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // AHB slave: data phase follows an accepted NONSEQ, sl_waits wait states, HRESP on the last two cycles when sl_err.
    always @(posedge HCLK) begin
        #1;
        if (!HRESETN) begin
            in_dp = 1'b0; dp_last = 1'b0; nonseq_acc = 1'b0;
            HREADY = 1'b1; HRESP = 1'b0;
        end else begin
            if (dp_last) begin
                in_dp = 1'b0; dp_last = 1'b0;
            end
            if (nonseq_acc) begin
                in_dp = 1'b1; wcnt = sl_waits;
            end
            if (in_dp) begin
                if (wcnt > 0) begin
                    HREADY = 1'b0; HRESP = sl_err && (wcnt == 1); wcnt--;
                end else begin
                    HREADY = 1'b1; HRESP = sl_err; HRDATA = sl_rdata;
                    dp_last = 1'b1; n_dp_done++;
                end
            end else begin
                HREADY = 1'b1; HRESP = 1'b0;
            end
            nonseq_acc = (HTRANS == 2'b10) && HREADY;
        end
    end

    always @(negedge HCLK) begin
        if (HTRANS == 2'b10) n_nonseq++;
        check("htrans_legal", {31'd0, (HTRANS == 2'b00) || (HTRANS == 2'b10)}, 32'd1);
        if (in_dp) check("htrans_idle_in_data", {30'd0, HTRANS}, 32'd0);
        if (!PREADY) check("pslverr_without_pready", {31'd0, PSLVERR}, 32'd0);
        if (PREADY) begin
            if (sb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_pready: got PREADY=1 at cycle %0d, expected no pending transfer", cyc);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_pslverr"}, {31'd0, PSLVERR}, {31'd0, mon_e.err});
                check({mon_e.name, "_prdata"}, PRDATA, mon_e.prdata);
                check({mon_e.name, "_cycle"}, cyc, mon_e.cyc);
            end
        end
    end

    task automatic apb_xfer(input string name, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int waits, input logic err, input int lat,
                            input logic exp_err, input bit expect_ready, input int budget);
        exp_t e;
        int   n;
        sl_waits = waits;
        sl_err   = err;
        sl_rdata = wr ? 32'hBAD0_0BAD : rdata;
        if (expect_ready) begin
            if (!wr) model_prdata = rdata;
            e.name = name; e.prdata = model_prdata; e.err = exp_err; e.cyc = cyc + lat;
            sb.push_back(e);
        end
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        n = 0;
        forever begin
            @(negedge HCLK);
            if (PREADY || n >= budget) break;
            n++;
        end
        if (expect_ready && !PREADY) begin
            n_checks++; n_fail++;
            $display("FAIL %s_timeout: got no PREADY within %0d cycles, expected PREADY", name, budget);
            void'(sb.pop_back());
        end
        @(posedge HCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        int d0;
        #12;
        check("rst_htrans", {30'd0, HTRANS}, 32'd0);
        check("rst_haddr", HADDR, 32'd0);
        check("rst_hwrite", {31'd0, HWRITE}, 32'd0);
        check("rst_hwdata", HWDATA, 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_pready", {31'd0, PREADY}, 32'd0);
        check("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        check("hsize", {29'd0, HSIZE}, 32'd2);
        check("hburst", {29'd0, HBURST}, 32'd0);
        check("hprot", {28'd0, HPROT}, 32'd3);
        check("hmastlock", {31'd0, HMASTLOCK}, 32'd0);
        @(negedge HCLK); HRESETN = 1'b1;
        @(posedge HCLK); #1;

        fork
            apb_xfer("wr_basic", 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, 3, 1'b0, 1'b1, 10);
            begin
                @(negedge HCLK);
                @(negedge HCLK);
                check("t1_htrans", {30'd0, HTRANS}, 32'd2);
                check("t1_haddr", HADDR, 32'h1000_0004);
                check("t1_hwrite", {31'd0, HWRITE}, 32'd1);
                @(negedge HCLK);
                check("t2_htrans", {30'd0, HTRANS}, 32'd0);
                check("t2_hwdata", HWDATA, 32'hDEAD_BEEF);
            end
        join

        apb_xfer("rd_wait3", 1'b0, 32'h2000_0010, 32'h0, 32'h1234_5678, 3, 1'b0, 6, 1'b0, 1'b1, 12);
        apb_xfer("wr_err", 1'b1, 32'h4000_0000, 32'h0000_0001, 32'h0, 1, 1'b1, 4, 1'b1, 1'b1, 10);
        apb_xfer("rd_after_err", 1'b0, 32'h4000_0004, 32'h0, 32'hCAFE_F00D, 0, 1'b0, 3, 1'b0, 1'b1, 10);

        n0 = n_nonseq;
        apb_xfer("b2b_rd0", 1'b0, 32'h5000_0000, 32'h0, 32'hA5A5_0001, 0, 1'b0, 3, 1'b0, 1'b1, 10);
        apb_xfer("b2b_wr", 1'b1, 32'h5000_0004, 32'h7777_1111, 32'h0, 0, 1'b0, 3, 1'b0, 1'b1, 10);
        apb_xfer("b2b_rd1", 1'b0, 32'h5000_0008, 32'h0, 32'h0F0F_F0F0, 0, 1'b0, 3, 1'b0, 1'b1, 10);
        check("b2b_nonseq_count", n_nonseq - n0, 32'd3);

        n0 = n_nonseq;
        d0 = n_dp_done;
        sl_waits = 2; sl_err = 1'b0; sl_rdata = 32'hFFFF_0000;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h6000_0000;
        @(posedge HCLK); #1; PENABLE = 1'b1;
        @(posedge HCLK); #1; PSEL = 1'b0; PENABLE = 1'b0;
        repeat (6) @(posedge HCLK);
        #1;
        check("drop_nonseq_count", n_nonseq - n0, 32'd1);
        check("drop_ahb_completed", n_dp_done - d0, 32'd1);
        apb_xfer("wr_after_drop", 1'b1, 32'h6000_0004, 32'h1357_2468, 32'h0, 0, 1'b0, 3, 1'b0, 1'b1, 10);

        fork
            apb_xfer("wr_reset", 1'b1, 32'h3000_0000, 32'h5555_AAAA, 32'h0, 3, 1'b0, 0, 1'b0, 1'b0, 8);
            begin
                @(negedge HCLK);
                @(negedge HCLK);
                @(negedge HCLK);
                #2; HRESETN = 1'b0; #1;
                check("arst_htrans", {30'd0, HTRANS}, 32'd0);
                check("arst_haddr", HADDR, 32'd0);
                check("arst_hwrite", {31'd0, HWRITE}, 32'd0);
                check("arst_hwdata", HWDATA, 32'd0);
                check("arst_prdata", PRDATA, 32'd0);
                check("arst_pready", {31'd0, PREADY}, 32'd0);
                check("arst_pslverr", {31'd0, PSLVERR}, 32'd0);
                model_prdata = 32'd0;
                @(negedge HCLK); HRESETN = 1'b1;
            end
        join
        apb_xfer("wr_after_rst", 1'b1, 32'h3000_0008, 32'h0BAD_CAFE, 32'h0, 0, 1'b0, 3, 1'b0, 1'b1, 10);

        repeat (3) @(posedge HCLK);
        #1;
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
